// File: rtl/audio_ctrl_pkg.sv
// Shared types for the lab3 audio slot controller.
//   state_e : top-level record/play state; the encoding is what o_state shows.
//   acc_e   : SRAM sequencer access phase.
package audio_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;
    localparam logic [1:0] ST_PAUSE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RECORD = ST_RECORD,
        PLAY   = ST_PLAY,
        PAUSE  = ST_PAUSE
    } state_e;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2,
        ACC_DONE = 2'd3
    } acc_e;

endpackage

// File: rtl/audio_sram_seq.sv
// Single-access asynchronous SRAM sequencer.
// An accepted request drives the strobes for exactly one cycle; a read
// captures dq at the end of that cycle and presents it with rvalid for one
// cycle. Only one access can be in flight: busy covers the strobe cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, we           request strobe, 1 = write / 0 = read
//   addr, wdata       access address and write data
//   busy              an access is on the SRAM bus this cycle
//   rdata, rvalid     captured read data and its 1-cycle valid
//   sram_addr         registered SRAM address
//   sram_dq           bidirectional data, driven only while we_n = 0
//   ce_n, oe_n, we_n  SRAM strobes (registered)
//   lb_n, ub_n        byte lanes, always enabled
module audio_sram_seq #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              lb_n,
    output logic              ub_n
);
    import audio_ctrl_pkg::*;

    acc_e              acc;
    acc_e              acc_n;
    logic              start;
    logic [DATA_W-1:0] wdata_q;

    assign busy   = (acc == ACC_WR) || (acc == ACC_RD);
    assign start  = req && !busy;
    assign rvalid = (acc == ACC_DONE);
    assign lb_n   = 1'b0;
    assign ub_n   = 1'b0;

    assign sram_dq = we_n ? {DATA_W{1'bz}} : wdata_q;

    always_comb begin
        acc_n = acc;
        case (acc)
            ACC_WR:  acc_n = ACC_IDLE;
            ACC_RD:  acc_n = ACC_DONE;
            // IDLE and DONE both accept a new access; DONE lasts one cycle.
            default: acc_n = start ? (we ? ACC_WR : ACC_RD) : ACC_IDLE;
        endcase
    end

    // Strobes are registered from the next phase so the SRAM never sees
    // decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= ACC_IDLE;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            sram_addr <= '0;
        end else begin
            acc  <= acc_n;
            ce_n <= !((acc_n == ACC_WR) || (acc_n == ACC_RD));
            oe_n <= (acc_n != ACC_RD);
            we_n <= (acc_n != ACC_WR);
            if (start) begin
                sram_addr <= addr;
            end
        end
    end

    // Data registers carry no reset; rvalid gates their use downstream.
    always_ff @(posedge clk) begin
        if (start) begin
            wdata_q <= wdata;
        end
        if (acc == ACC_RD) begin
            rdata <= sram_dq;
        end
    end

endmodule

// File: rtl/audio_slot_ctrl.sv
// Multi-slot record/play controller for the lab3 audio recorder.
// The SRAM is split into N_SLOTS equal slots addressed as {slot, offset}.
// A per-slot length table stops playback at the recorded end.
// Optional build macro: LOOP_PLAY_EN - playback wraps to offset 0 at the
// recorded end and stays in PLAY (o_play_finish still pulses).
// Ports:
//   i_bclk, i_rst                clock, asynchronous active-low reset
//   i_key_rec/play/pause/stop    1-cycle key pulses (stop > rec > play > pause)
//   i_slot                       slot select, used only on accepted rec/play
//   i_rec_valid, i_rec_data      recorded sample strobe and data
//   i_play_req                   player asks for the next sample
//   o_play_data, o_play_valid    returned sample (0 = silence outside PLAY)
//   o_sram_addr, io_sram_dq      SRAM address and data bus
//   o_sram_ce_n/oe_n/we_n/lb_n/ub_n  SRAM strobes
//   o_state                      0 IDLE, 1 RECORD, 2 PLAY, 3 PAUSE
//   o_offset                     offset within the active slot
//   o_slot_valid                 bit s set when slot s holds a sample
//   o_rec_finish, o_play_finish  end-of-slot / end-of-recording pulses
//   o_ovf                        sticky: a sample strobe was dropped
module audio_slot_ctrl #(
    parameter int  ADDR_W  = 20,
    parameter int  DATA_W  = 16,
    parameter int  N_SLOTS = 4,
    localparam int SLOT_W  = $clog2(N_SLOTS),
    localparam int OFF_W   = ADDR_W - SLOT_W
) (
    input  logic               i_bclk,
    input  logic               i_rst,
    input  logic               i_key_rec,
    input  logic               i_key_play,
    input  logic               i_key_pause,
    input  logic               i_key_stop,
    input  logic [SLOT_W-1:0]  i_slot,
    input  logic               i_rec_valid,
    input  logic [DATA_W-1:0]  i_rec_data,
    input  logic               i_play_req,
    output logic [DATA_W-1:0]  o_play_data,
    output logic               o_play_valid,
    output logic [ADDR_W-1:0]  o_sram_addr,
    inout  wire  [DATA_W-1:0]  io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n,
    output logic [1:0]         o_state,
    output logic [OFF_W-1:0]   o_offset,
    output logic [N_SLOTS-1:0] o_slot_valid,
    output logic               o_rec_finish,
    output logic               o_play_finish,
    output logic               o_ovf
);
    import audio_ctrl_pkg::*;

`ifdef LOOP_PLAY_EN
    localparam bit LOOP_PLAY = 1'b1;
`else
    localparam bit LOOP_PLAY = 1'b0;
`endif

    localparam logic [OFF_W-1:0] OFF_MAX = '1;

    state_e            state;
    state_e            state_n;
    logic [SLOT_W-1:0] act_slot;
    logic [OFF_W-1:0]  offset;
    // One extra bit so a completely filled slot is representable.
    logic [OFF_W:0]    len [N_SLOTS];
    logic [OFF_W:0]    off_inc;
    logic [OFF_W:0]    cur_len;

    logic wr_pend;
    logic rd_pend;
    logic sil_p0;
    logic sil_p1;
    logic rec_finish;
    logic play_finish;
    logic ovf;

    logic acc_wr;
    logic acc_rd;
    logic silent;
    logic drop;
    logic rec_end;
    logic play_end;
    logic end_now;
    logic start_rec;
    logic start_play;

    logic              seq_busy;
    logic              seq_rvalid;
    logic [DATA_W-1:0] seq_rdata;

    assign off_inc = {1'b0, offset} + 1'b1;
    assign cur_len = len[act_slot];

    for (genvar s = 0; s < N_SLOTS; s++) begin : g_valid
        assign o_slot_valid[s] = (len[s] != '0);
    end

    // Access acceptance and completion events.
    always_comb begin
        acc_wr   = (state == RECORD) && i_rec_valid && !seq_busy;
        acc_rd   = (state == PLAY) && i_play_req && !seq_busy;
        silent   = i_play_req && (state != PLAY);
        drop     = seq_busy && (((state == RECORD) && i_rec_valid) ||
                                ((state == PLAY) && i_play_req));
        rec_end  = wr_pend && (state == RECORD) && (offset == OFF_MAX);
        play_end = rd_pend && ((state == PLAY) || (state == PAUSE)) &&
                   (off_inc == cur_len);
        end_now  = rec_end || (play_end && !LOOP_PLAY);
    end

    // Next-state: end-of-slot/recording first, then the highest-priority key.
    always_comb begin
        state_n    = state;
        start_rec  = 1'b0;
        start_play = 1'b0;
        if (end_now) begin
            state_n = IDLE;
        end
        if (i_key_stop) begin
            state_n = IDLE;
        end else if (i_key_rec) begin
            if (state == IDLE) begin
                state_n   = RECORD;
                start_rec = 1'b1;
            end
        end else if (i_key_play) begin
            if ((state == IDLE) && o_slot_valid[i_slot]) begin
                state_n    = PLAY;
                start_play = 1'b1;
            end
        end else if (i_key_pause && !end_now) begin
            if (state == PLAY) begin
                state_n = PAUSE;
            end else if (state == PAUSE) begin
                state_n = PLAY;
            end
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst) begin
        if (!i_rst) begin
            act_slot    <= '0;
            offset      <= '0;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            sil_p0      <= 1'b0;
            sil_p1      <= 1'b0;
            rec_finish  <= 1'b0;
            play_finish <= 1'b0;
            ovf         <= 1'b0;
            for (int s = 0; s < N_SLOTS; s++) begin
                len[s] <= '0;
            end
        end else begin
            wr_pend     <= acc_wr;
            rd_pend     <= acc_rd;
            sil_p0      <= silent;
            sil_p1      <= sil_p0;
            rec_finish  <= rec_end;
            play_finish <= play_end;
            if (drop) begin
                ovf <= 1'b1;
            end
            // A write that was already on the bus still counts after stop.
            if (wr_pend) begin
                len[act_slot] <= off_inc;
                offset        <= off_inc[OFF_W-1:0];
            end
            if (rd_pend && (state != IDLE)) begin
                offset <= (play_end && LOOP_PLAY) ? '0 : off_inc[OFF_W-1:0];
            end
            if (start_rec) begin
                act_slot    <= i_slot;
                offset      <= '0;
                len[i_slot] <= '0;
            end
            if (start_play) begin
                act_slot <= i_slot;
                offset   <= '0;
            end
        end
    end

    audio_sram_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq (
        .clk       (i_bclk),
        .rst_n     (i_rst),
        .req       (acc_wr || acc_rd),
        .we        (acc_wr),
        .addr      ({act_slot, offset}),
        .wdata     (i_rec_data),
        .busy      (seq_busy),
        .rdata     (seq_rdata),
        .rvalid    (seq_rvalid),
        .sram_addr (o_sram_addr),
        .sram_dq   (io_sram_dq),
        .ce_n      (o_sram_ce_n),
        .oe_n      (o_sram_oe_n),
        .we_n      (o_sram_we_n),
        .lb_n      (o_sram_lb_n),
        .ub_n      (o_sram_ub_n)
    );

    // Silence responses share the same two-cycle latency as SRAM reads.
    assign o_play_valid  = seq_rvalid || sil_p1;
    assign o_play_data   = seq_rvalid ? seq_rdata : '0;
    assign o_state       = state;
    assign o_offset      = offset;
    assign o_rec_finish  = rec_finish;
    assign o_play_finish = play_finish;
    assign o_ovf         = ovf;

endmodule

// File: tb/tb_audio_slot_ctrl.sv
// Bench for audio_slot_ctrl (ADDR_W=6, N_SLOTS=4 -> 16 words per slot).
// A behavioural SRAM model hangs off the bus. Stimulus tasks update a
// high-level reference model (per-slot lengths, sample memory, state) and
// push expected SRAM writes and player responses into queues; a monitor
// pops and compares them when the DUT presents a write strobe or play valid.
module tb_audio_slot_ctrl;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int N_SLOTS = 4;
    localparam int DEPTH   = 16;

    localparam int K_REC     = 0;
    localparam int K_PLAY    = 1;
    localparam int K_PAUSE   = 2;
    localparam int K_STOP    = 3;
    localparam int K_STOPREC = 4;
    localparam int K_RV      = 5;
    localparam int K_PR      = 6;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        key_rec   = 1'b0;
    logic        key_play  = 1'b0;
    logic        key_pause = 1'b0;
    logic        key_stop  = 1'b0;
    logic [1:0]  slot      = 2'd0;
    logic        rec_valid = 1'b0;
    logic [15:0] rec_data  = 16'h0;
    logic        play_req  = 1'b0;

    logic [15:0] play_data;
    logic        play_valid;
    logic [5:0]  sram_addr;
    wire  [15:0] dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic [1:0]  state;
    logic [3:0]  offset;
    logic [3:0]  slot_valid;
    logic        rec_finish, play_finish, ovf;

    logic [15:0] sram [64] = '{default: 16'h0};

    always #5 clk = ~clk;

    audio_slot_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .N_SLOTS (N_SLOTS)
    ) dut (
        .i_bclk        (clk),
        .i_rst         (rst_n),
        .i_key_rec     (key_rec),
        .i_key_play    (key_play),
        .i_key_pause   (key_pause),
        .i_key_stop    (key_stop),
        .i_slot        (slot),
        .i_rec_valid   (rec_valid),
        .i_rec_data    (rec_data),
        .i_play_req    (play_req),
        .o_play_data   (play_data),
        .o_play_valid  (play_valid),
        .o_sram_addr   (sram_addr),
        .io_sram_dq    (dq),
        .o_sram_ce_n   (ce_n),
        .o_sram_oe_n   (oe_n),
        .o_sram_we_n   (we_n),
        .o_sram_lb_n   (lb_n),
        .o_sram_ub_n   (ub_n),
        .o_state       (state),
        .o_offset      (offset),
        .o_slot_valid  (slot_valid),
        .o_rec_finish  (rec_finish),
        .o_play_finish (play_finish),
        .o_ovf         (ovf)
    );

    // Asynchronous SRAM: reads while ce/oe low, writes latched on the clock.
    assign dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr] : 16'bz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) sram[sram_addr] <= dq;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int data; int fin; int cyc; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    int ncyc    = 0;
    int rf_seen = 0;

    always @(negedge clk) ncyc <= ncyc + 1;

    // Reference model state.
    int m_state;
    int m_slot;
    int m_off;
    int m_rf;
    int m_len [N_SLOTS];
    int m_mem [64] = '{default: 0};
    int m_ovf;

    task automatic model_reset();
        m_state = 0;
        m_slot  = 0;
        m_off   = 0;
        m_rf    = 0;
        m_ovf   = 0;
        for (int s = 0; s < N_SLOTS; s++) m_len[s] = 0;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ce_n && !we_n) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", int'(sram_addr), -1);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", int'(sram_addr), w.addr);
                    chk("wr_data", int'(dq), w.data);
                    chk("wr_cycle", ncyc, w.cyc);
                end
            end
            if (play_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", int'(play_data), -1);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    chk("rd_data", int'(play_data), r.data);
                    chk("rd_finish", int'(play_finish), r.fin);
                    chk("rd_cycle", ncyc, r.cyc);
                end
            end else if (play_finish) begin
                chk("play_finish_without_valid", 1, 0);
            end
            if (rec_finish) rf_seen <= rf_seen + 1;
        end
    end

    function automatic int model_sv();
        int v = 0;
        for (int s = 0; s < N_SLOTS; s++) if (m_len[s] != 0) v |= (1 << s);
        return v;
    endfunction

    task automatic check_state();
        chk("state", int'(state), m_state);
        chk("offset", int'(offset), m_off % DEPTH);
        chk("slot_valid", int'(slot_valid), model_sv());
        chk("ovf", int'(ovf), m_ovf);
        chk("wr_outstanding", wr_q.size(), 0);
        chk("rd_outstanding", rd_q.size(), 0);
        chk("rec_finish_count", rf_seen, m_rf);
    endtask

    task automatic reset_checks();
        chk("rst_ce_n", int'(ce_n), 1);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_we_n", int'(we_n), 1);
        chk("rst_lb_n", int'(lb_n), 0);
        chk("rst_ub_n", int'(ub_n), 0);
        chk("rst_addr", int'(sram_addr), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_slot_valid", int'(slot_valid), 0);
        chk("rst_offset", int'(offset), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_play_valid", int'(play_valid), 0);
        chk("rst_play_data", int'(play_data), 0);
        chk("rst_pulses", int'({rec_finish, play_finish}), 0);
    endtask

    // Rec-valid step of the model: one sample into the active slot.
    task automatic model_write(input int d);
        int a;
        a = m_slot * DEPTH + m_off;
        wr_q.push_back('{a, d, ncyc + 1});
        m_mem[a] = d;
        m_off++;
        m_len[m_slot] = m_off;
        if (m_off == DEPTH) begin
            m_rf++;
            m_state = 0;
        end
    endtask

    // Issue one spaced operation; the model decides the expected response.
    task automatic op(input int kind, input int s, input int d);
        int a;
        int fin;
        slot = 2'(s);
        case (kind)
            K_REC: begin
                key_rec = 1'b1;
                if (m_state == 0) begin
                    m_state = 1; m_slot = s; m_off = 0; m_len[s] = 0;
                end
            end
            K_PLAY: begin
                key_play = 1'b1;
                if (m_state == 0 && m_len[s] != 0) begin
                    m_state = 2; m_slot = s; m_off = 0;
                end
            end
            K_PAUSE: begin
                key_pause = 1'b1;
                if (m_state == 2) m_state = 3;
                else if (m_state == 3) m_state = 2;
            end
            K_STOP: begin
                key_stop = 1'b1;
                m_state = 0;
            end
            K_STOPREC: begin
                key_stop = 1'b1;
                key_rec  = 1'b1;
                m_state  = 0;
            end
            K_RV: begin
                rec_valid = 1'b1;
                rec_data  = 16'(d);
                if (m_state == 1) model_write(d & 16'hffff);
            end
            default: begin
                play_req = 1'b1;
                if (m_state == 2) begin
                    a = m_slot * DEPTH + m_off;
                    m_off++;
                    fin = (m_off == m_len[m_slot]) ? 1 : 0;
                    rd_q.push_back('{m_mem[a], fin, ncyc + 2});
                    if (fin == 1) begin
`ifdef LOOP_PLAY_EN
                        m_off = 0;
`else
                        m_state = 0;
`endif
                    end
                end else begin
                    rd_q.push_back('{0, 0, ncyc + 2});
                end
            end
        endcase
        @(posedge clk); #1;
        key_rec = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
        rec_valid = 1'b0; play_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        model_reset();
        #12;
        reset_checks();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while a write is on the bus.
        op(K_REC, 1, 0);
        rec_valid = 1'b1;
        rec_data  = 16'hdead;
        @(posedge clk); #1;
        rec_valid = 1'b0;
        chk("t1_write_active", int'(we_n), 0);
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Record five samples into slot 2.
        op(K_REC, 2, 0);
        for (int i = 1; i <= 5; i++) op(K_RV, 0, i * 16'h1111);
        op(K_STOP, 0, 0);
        chk("t2_slot_valid", int'(slot_valid), 4'b0100);

        // Play slot 2: five samples, finish on the fifth, then silence.
        op(K_PLAY, 2, 0);
        for (int i = 0; i < 6; i++) op(K_PR, 0, 0);
        chk("t3_state", int'(state), 0);

        // Fill slot 0; extra samples after the end are ignored.
        op(K_REC, 0, 0);
        for (int i = 0; i < 20; i++) op(K_RV, 0, int'($urandom_range(0, 16'hffff)));
        chk("t4_slot_valid", int'(slot_valid), 4'b0101);

        // Pause returns silence and holds the offset.
        op(K_PLAY, 2, 0);
        op(K_PR, 0, 0);
        op(K_PR, 0, 0);
        op(K_PAUSE, 0, 0);
        for (int i = 0; i < 3; i++) op(K_PR, 0, 0);
        op(K_PAUSE, 0, 0);
        op(K_PR, 0, 0);
        op(K_STOP, 0, 0);

        // Key priority, empty slot, dropped sample.
        op(K_STOPREC, 0, 0);
        op(K_PLAY, 1, 0);
        op(K_REC, 3, 0);
        rec_valid = 1'b1;
        rec_data  = 16'haaaa;
        model_write(16'haaaa);
        @(posedge clk); #1;
        rec_data = 16'hbbbb;
        m_ovf    = 1;
        @(posedge clk); #1;
        rec_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("t6_ovf", int'(ovf), 1);
        op(K_STOP, 0, 0);

        // Randomized operation mix against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 2)       op(K_REC, int'($urandom_range(0, 3)), 0);
            else if (r < 4)  op(K_PLAY, int'($urandom_range(0, 3)), 0);
            else if (r == 4) op(K_PAUSE, 0, 0);
            else if (r == 5) op(K_STOP, 0, 0);
            else if (r < 11) op(K_RV, 0, int'($urandom_range(0, 16'hffff)));
            else             op(K_PR, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
